powerup_ctrl: RTL and testbench
===============================

# powerup_ctrl

Power-state controller for the player character. It takes the collision pulses produced by the item and enemy object blocks (mushroom, flower, 1-up, enemy hit), edge-detects and arbitrates them, and sequences the grow, shrink and death transitions on frame ticks. It drives the power level, game freeze, flicker, invulnerability and life count that the game-calc top and the renderer consume.

## Interface
Parameters:
- GROW_FRAMES, 48: frames of freeze for a grow or shrink transition.
- INV_FRAMES, 120: invulnerability frames after a shrink.
- DEATH_FRAMES, 90: frames of freeze for the death sequence.
- FLICK_PERIOD, 4: frames per toggle of anim_phase (power of 2).
- LIFE_INIT, 3: life count after reset.

Ports:
- sys_clk  in  1  system clock.
- RST_N  in  1  reset; asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- touch_mush  in  1  mushroom collision (level or pulse).
- touch_flower  in  1  flower collision.
- touch_1up  in  1  1-up collision.
- touch_enemy  in  1  damaging contact.
- power_state  out  2  0 = SMALL, 1 = BIG, 2 = FIRE; 3 is never driven.
- freeze  out  1  high while a transition is running; the game world halts.
- anim_phase  out  1  flicker bit for the renderer.
- invuln  out  1  damage is ignored while high.
- life_cnt  out  4  lives, 0..9.
- dead_pulse  out  1  one cycle at the end of the death sequence.
- game_over  out  1  sticky until reset.

## Operation
- Each touch input is rising-edge detected on sys_clk. Only a 0→1 transition counts as an event.
- Each item kind has a pending flag (mush, flower, 1up). An edge sets its flag in any state. The flag clears when the event is consumed.
- FSM states and behaviour:
  - IDLE: freeze=0. Consumes at most one event per cycle, in this priority: enemy > mush > flower > 1up.
  - GROW: freeze=1. Runs GROW_FRAMES frame ticks, then power_state is incremented and the FSM returns to IDLE.
  - SHRINK: freeze=1. Runs GROW_FRAMES frame ticks, then power_state=SMALL, the invuln timer is loaded with INV_FRAMES, and the FSM returns to IDLE.
  - DYING: freeze=1. Runs DEATH_FRAMES frame ticks, then dead_pulse is asserted for one cycle, power_state=SMALL, life_cnt is decremented, and the FSM returns to IDLE. If life_cnt was 1, game_over is set and the FSM goes to OVER.
  - OVER: freeze=1 forever. All events are ignored.
- Event handling in IDLE:
  - Enemy edge with invuln=0: power_state SMALL → DYING; otherwise → SHRINK. An enemy edge with invuln=1 is discarded and is not latched.
  - Mush: SMALL → GROW; BIG or FIRE → no state change, flag cleared.
  - Flower: SMALL or BIG → GROW. A flower taken while SMALL goes directly to FIRE: the power_state update is set to 2, not incremented. FIRE → flag cleared, no change.
  - 1up: life_cnt increments, saturating at 9. No state change.
- Enemy edges that arrive outside IDLE are discarded.
- Invulnerability timer (width fits INV_FRAMES): decrements on frame_tick while nonzero, and keeps running in IDLE. invuln = (timer≠0).
- Frame counter: clears on every FSM state entry and increments on frame_tick. A transition ends on the tick that brings the count to the state's frame limit.
- anim_phase:
  - GROW and SHRINK: the counter bit selected by FLICK_PERIOD.
  - IDLE with invuln=1: the same bit.
  - Otherwise 0.

## Timing
- Reset values:
  - Outputs: power_state=0, freeze=0, anim_phase=0, invuln=0, life_cnt=LIFE_INIT, dead_pulse=0, game_over=0.
  - Internal: FSM=IDLE, all pending flags and edge registers clear, all timers 0.
- Latency from a touch rising edge (sampled at clock edge N):
  - The edge is registered at N+1.
  - The FSM leaves IDLE, or life_cnt updates, at N+2.
  - freeze rises at N+2.
- freeze falls, and power_state updates, on the same clock as the final frame_tick of the transition, plus 1 cycle.
- A frame_tick coincident with state entry is not counted.
- Reset asserted mid-transition returns immediately to reset values, asynchronously. Pending flags are lost.
- A held-high touch input produces exactly one event.

## Test plan
- Reset, then a mush edge while SMALL: freeze=1 for exactly 48 frame ticks, anim_phase toggles every 4 ticks, then power_state=1 and freeze=0.
- Flower edge while SMALL: the FSM passes through GROW and ends with power_state=2. A second flower edge while FIRE produces no freeze and no state change.
- BIG, then an enemy edge: SHRINK for 48 ticks, then power_state=0 and invuln=1 for 120 ticks. An enemy edge at tick 60 of invulnerability is ignored; an enemy edge at tick 121 leads to DYING.
- Mush and enemy edges in the same cycle while SMALL, invuln=0: the FSM enters DYING. The mush stays pending and is consumed in the cycle after the return to IDLE, leading to GROW.
- life_cnt=1, then death: after 90 ticks, dead_pulse for one cycle, life_cnt=0, game_over=1, freeze stuck at 1. Ten 1up edges from life_cnt=3 saturate at 9.
- Assert RST_N low in the middle of GROW: all outputs return to their reset values immediately, and no power_state change occurs.

Source files
------------

// File: rtl/powerup_ctrl.sv
// Player power-state controller: edge-detects item/enemy touches and
// sequences grow, shrink and death transitions on frame ticks.
module powerup_ctrl #(
  parameter int GROW_FRAMES  = 48,
  parameter int INV_FRAMES   = 120,
  parameter int DEATH_FRAMES = 90,
  parameter int FLICK_PERIOD = 4,
  parameter int LIFE_INIT    = 3
) (
  input  logic       sys_clk,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       touch_mush,
  input  logic       touch_flower,
  input  logic       touch_1up,
  input  logic       touch_enemy,
  output logic [1:0] power_state,
  output logic       freeze,
  output logic       anim_phase,
  output logic       invuln,
  output logic [3:0] life_cnt,
  output logic       dead_pulse,
  output logic       game_over
);

  localparam int MAXF = (GROW_FRAMES > DEATH_FRAMES) ?
                        GROW_FRAMES : DEATH_FRAMES;
  localparam int FW = $clog2(MAXF + 1);
  localparam int IW = $clog2(INV_FRAMES + 1);
  localparam int FB = $clog2(FLICK_PERIOD);

  localparam logic [FW-1:0] GROW_LAST  = FW'(GROW_FRAMES - 1);
  localparam logic [FW-1:0] DEATH_LAST = FW'(DEATH_FRAMES - 1);
  localparam logic [IW-1:0] INV_LOAD   = IW'(INV_FRAMES);
  localparam logic [3:0]    LIFE_RST   = 4'(LIFE_INIT);

  localparam logic [1:0] PW_SMALL = 2'd0;
  localparam logic [1:0] PW_BIG   = 2'd1;
  localparam logic [1:0] PW_FIRE  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GROW,
    S_SHRINK,
    S_DYING,
    S_OVER
  } state_t;

  // bit 0 mush, 1 flower, 2 1up, 3 enemy
  logic [3:0]    in_q, in_qq, edge_q;
  logic [2:0]    pend_q, pend_d, avail;
  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [IW-1:0] inv_q, inv_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [1:0]    power_q, power_d;
  logic [3:0]    life_q, life_d;
  logic          freeze_q, freeze_d;
  logic          anim_q, anim_d;
  logic          invuln_q;
  logic          dead_q, dead_d;
  logic          over_q, over_d;
  logic          enter;
  logic          hit_en, take_m, take_f, take_u;

  logic [3:0] touch;
  assign touch = {touch_enemy, touch_1up,
                  touch_flower, touch_mush};

  // Arbitration terms, made mutually exclusive in priority order.
  assign avail  = pend_q | edge_q[2:0];
  assign hit_en = edge_q[3] & (inv_q == '0);
  assign take_m = avail[0] & ~hit_en;
  assign take_f = avail[1] & ~hit_en & ~avail[0];
  assign take_u = avail[2] & ~hit_en & ~avail[0] & ~avail[1];

  // Next-state, timer and output computation.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    inv_d   = inv_q;
    tgt_d   = tgt_q;
    power_d = power_q;
    life_d  = life_q;
    dead_d  = 1'b0;
    over_d  = over_q;
    pend_d  = avail;
    enter   = 1'b0;
    if (frame_tick && inv_q != '0) inv_d = inv_q - 1'b1;
    if (frame_tick) fcnt_d = fcnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          hit_en: begin
            enter   = 1'b1;
            state_d = (power_q == PW_SMALL) ? S_DYING : S_SHRINK;
          end
          take_m: begin
            pend_d[0] = 1'b0;
            if (power_q == PW_SMALL) begin
              state_d = S_GROW;
              tgt_d   = PW_BIG;
              enter   = 1'b1;
            end
          end
          take_f: begin
            pend_d[1] = 1'b0;
            if (power_q != PW_FIRE) begin
              state_d = S_GROW;
              tgt_d   = PW_FIRE;
              enter   = 1'b1;
            end
          end
          take_u: begin
            pend_d[2] = 1'b0;
            if (life_q != 4'd9) life_d = life_q + 4'd1;
          end
          default: ;
        endcase
      end
      S_GROW: begin
        if (frame_tick && fcnt_q == GROW_LAST) begin
          power_d = tgt_q;
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      end
      S_SHRINK: begin
        if (frame_tick && fcnt_q == GROW_LAST) begin
          power_d = PW_SMALL;
          inv_d   = INV_LOAD;
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      end
      S_DYING: begin
        if (frame_tick && fcnt_q == DEATH_LAST) begin
          dead_d  = 1'b1;
          power_d = PW_SMALL;
          life_d  = life_q - 4'd1;
          enter   = 1'b1;
          if (life_q == 4'd1) begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_OVER: ;
      default: state_d = S_IDLE;
    endcase
    if (enter) fcnt_d = '0;
    freeze_d = (state_d != S_IDLE);
    anim_d   = 1'b0;
    if (state_d == S_GROW || state_d == S_SHRINK ||
        (state_d == S_IDLE && inv_d != '0))
      anim_d = fcnt_d[FB];
  end

  // State, timers, edge detectors and registered outputs.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      in_q     <= '0;
      in_qq    <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      state_q  <= S_IDLE;
      fcnt_q   <= '0;
      inv_q    <= '0;
      tgt_q    <= PW_SMALL;
      power_q  <= PW_SMALL;
      life_q   <= LIFE_RST;
      freeze_q <= 1'b0;
      anim_q   <= 1'b0;
      invuln_q <= 1'b0;
      dead_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      in_q     <= touch;
      in_qq    <= in_q;
      edge_q   <= in_q & ~in_qq;
      pend_q   <= pend_d;
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      inv_q    <= inv_d;
      tgt_q    <= tgt_d;
      power_q  <= power_d;
      life_q   <= life_d;
      freeze_q <= freeze_d;
      anim_q   <= anim_d;
      invuln_q <= (inv_d != '0);
      dead_q   <= dead_d;
      over_q   <= over_d;
    end
  end

  assign power_state = power_q;
  assign freeze      = freeze_q;
  assign anim_phase  = anim_q;
  assign invuln      = invuln_q;
  assign life_cnt    = life_q;
  assign dead_pulse  = dead_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// Scoreboard bench for powerup_ctrl: a transition-level reference model
// predicts every output change; a monitor matches the DUT's changes.
module tb_powerup_ctrl;

  localparam int GF = 48;
  localparam int IV = 120;
  localparam int DF = 90;
  localparam int FP = 4;
  localparam int LI = 3;

  localparam logic [3:0] TM = 4'b0001;
  localparam logic [3:0] TF = 4'b0010;
  localparam logic [3:0] TU = 4'b0100;
  localparam logic [3:0] TE = 4'b1000;

  logic sys_clk = 1'b0;
  logic RST_N = 1'b1;
  logic frame_tick = 1'b0;
  logic touch_mush = 1'b0;
  logic touch_flower = 1'b0;
  logic touch_1up = 1'b0;
  logic touch_enemy = 1'b0;
  logic [1:0] power_state;
  logic freeze, anim_phase, invuln;
  logic [3:0] life_cnt;
  logic dead_pulse, game_over;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  powerup_ctrl #(
    .GROW_FRAMES(GF), .INV_FRAMES(IV), .DEATH_FRAMES(DF),
    .FLICK_PERIOD(FP), .LIFE_INIT(LI)
  ) dut (
    .sys_clk(sys_clk), .RST_N(RST_N), .frame_tick(frame_tick),
    .touch_mush(touch_mush), .touch_flower(touch_flower),
    .touch_1up(touch_1up), .touch_enemy(touch_enemy),
    .power_state(power_state), .freeze(freeze),
    .anim_phase(anim_phase), .invuln(invuln),
    .life_cnt(life_cnt), .dead_pulse(dead_pulse),
    .game_over(game_over)
  );

  typedef struct packed {
    logic [1:0] pw;
    logic fz;
    logic an;
    logic iv;
    logic [3:0] lf;
    logic dp;
    logic go;
  } ov_t;

  typedef struct {
    int  cyc;
    ov_t v;
  } rec_t;

  rec_t sbq[$];
  bit   mon_en = 1'b0;
  int   cyc = 0;

  // reference model: a transition is "busy for total ticks, then apply
  // its end effect"; touch edges act two clocks after being sampled
  logic [3:0] m_prev, m_e1, m_e2;
  logic [2:0] m_pend;
  bit m_busy, m_die, m_ldinv, m_over, m_go, m_dead;
  int m_el, m_total, m_tgt, m_pw, m_life, m_inv;
  ov_t exp_prev;

  function automatic ov_t model_out();
    ov_t o;
    bit ph;
    ph = ((m_el / FP) % 2) == 1;
    o.pw = 2'(m_pw);
    o.fz = m_busy || m_over;
    if (m_over) o.an = 1'b0;
    else if (m_busy) o.an = !m_die && ph;
    else o.an = (m_inv != 0) && ph;
    o.iv = (m_inv != 0);
    o.lf = 4'(m_life);
    o.dp = m_dead;
    o.go = m_go;
    return o;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_e1 = '0; m_e2 = '0; m_pend = '0;
    m_busy = 0; m_die = 0; m_ldinv = 0; m_over = 0;
    m_go = 0; m_dead = 0;
    m_el = 0; m_total = 0; m_tgt = 0; m_pw = 0;
    m_life = LI; m_inv = 0;
  endtask

  task automatic start(input int total, input bit die,
                       input bit ldinv, input int tgt);
    m_busy = 1; m_el = 0; m_total = total;
    m_die = die; m_ldinv = ldinv; m_tgt = tgt;
  endtask

  task automatic model_step();
    logic [3:0] t, ev, act;
    bit inv_old, started;
    t = {touch_enemy, touch_1up, touch_flower, touch_mush};
    ev = t & ~m_prev;
    m_prev = t;
    act = m_e2; m_e2 = m_e1; m_e1 = ev;
    inv_old = (m_inv != 0);
    m_dead = 0;
    started = 0;
    m_pend = m_pend | act[2:0];
    if (frame_tick && m_inv > 0) m_inv--;
    if (m_over) begin
    end else if (m_busy) begin
      if (frame_tick) begin
        m_el++;
        if (m_el == m_total) begin
          m_busy = 0;
          m_el = 0;
          if (m_die) begin
            m_dead = 1;
            m_pw = 0;
            m_life--;
            if (m_life == 0) begin
              m_over = 1;
              m_go = 1;
            end
          end else begin
            m_pw = m_tgt;
            if (m_ldinv) m_inv = IV;
          end
        end
      end
    end else begin
      if (act[3] && !inv_old) begin
        if (m_pw == 0) start(DF, 1, 0, 0);
        else start(GF, 0, 1, 0);
        started = 1;
      end else if (m_pend[0]) begin
        m_pend[0] = 0;
        if (m_pw == 0) begin start(GF, 0, 0, 1); started = 1; end
      end else if (m_pend[1]) begin
        m_pend[1] = 0;
        if (m_pw < 2) begin start(GF, 0, 0, 2); started = 1; end
      end else if (m_pend[2]) begin
        m_pend[2] = 0;
        if (m_life < 9) m_life++;
      end
      if (!started && frame_tick) m_el++;
    end
  endtask

  // model advances with the DUT and queues each predicted output change
  always @(posedge sys_clk or negedge RST_N) begin
    ov_t o;
    if (!RST_N) model_reset();
    else begin
      cyc++;
      model_step();
    end
    o = model_out();
    if (o != exp_prev) begin
      if (mon_en) sbq.push_back('{cyc, o});
      exp_prev = o;
    end
  end

  // monitor: every observed DUT output change consumes one prediction
  ov_t dut_prev;
  always @(negedge sys_clk) begin
    ov_t d;
    rec_t r;
    d = {power_state, freeze, anim_phase, invuln,
         life_cnt, dead_pulse, game_over};
    if (mon_en && d !== dut_prev) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL out_change cyc %0d got %h, none expected",
                 cyc, d);
      end else begin
        r = sbq.pop_front();
        if (r.v !== d || r.cyc != cyc) begin
          errors++;
          $display("FAIL out_change got %h at cyc %0d, need %h at cyc %0d",
                   d, cyc, r.v, r.cyc);
        end
      end
    end
    dut_prev = d;
  end

  task automatic cycle(input logic [3:0] t);
    @(posedge sys_clk);
    #1;
    {touch_enemy, touch_1up, touch_flower, touch_mush} = t;
    frame_tick = ($urandom_range(0, 1) == 1);
  endtask

  task automatic touch(input logic [3:0] t, input int hold);
    for (int i = 0; i < hold; i++) cycle(t);
    cycle(4'b0000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000);
  endtask

  task automatic run_ticks(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 20 * n + 20) begin
      cycle(4'b0000);
      guard++;
      if (frame_tick) got++;
    end
  endtask

  task automatic wait_free(input string tag);
    int guard = 0;
    while ((m_busy || m_pend != 0 || m_e1 != 0 || m_e2 != 0)
           && !m_over && guard < 4000) begin
      cycle(4'b0000);
      guard++;
    end
    checks++;
    if (guard >= 4000) begin
      errors++;
      $display("FAIL %s timeout got busy, need idle", tag);
    end
  endtask

  task automatic wait_inv_clear();
    int guard = 0;
    while (m_inv != 0 && guard < 4000) begin
      cycle(4'b0000);
      guard++;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    RST_N = 1'b0;
    {touch_enemy, touch_1up, touch_flower, touch_mush} = 4'b0000;
    frame_tick = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic chk(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, got, need);
    end
  endtask

  initial begin
    #1 RST_N = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 RST_N = 1'b1;
    @(negedge sys_clk);
    chk("rst_power", int'(power_state), 0);
    chk("rst_freeze", int'(freeze), 0);
    chk("rst_anim", int'(anim_phase), 0);
    chk("rst_invuln", int'(invuln), 0);
    chk("rst_life", int'(life_cnt), LI);
    chk("rst_dead", int'(dead_pulse), 0);
    chk("rst_over", int'(game_over), 0);
    mon_en = 1'b1;

    touch(TM, 3);
    wait_free("grow_mush");
    chk("pw_after_mush", int'(power_state), 1);
    touch(TF, 1);
    wait_free("grow_flower");
    chk("pw_after_flower", int'(power_state), 2);
    touch(TF, 2);
    wait_free("flower_fire");
    idle(4);
    chk("fire_no_freeze", int'(freeze), 0);

    touch(TE, 1);
    wait_free("shrink");
    chk("pw_after_shrink", int'(power_state), 0);
    run_ticks(60);
    touch(TE, 2);
    wait_free("enemy_invuln");
    chk("inv_hit_ignored", int'(life_cnt), LI);
    wait_inv_clear();
    run_ticks(1);
    touch(TE, 1);
    wait_free("die_small");
    chk("life_after_die", int'(life_cnt), LI - 1);

    touch(TM | TE, 1);
    wait_free("die_then_grow");
    chk("pw_die_then_grow", int'(power_state), 1);
    chk("life_die_then_grow", int'(life_cnt), LI - 2);

    touch(TE, 1);
    wait_free("shrink2");
    wait_inv_clear();
    run_ticks(2);
    touch(TE, 1);
    wait_free("final_death");
    idle(8);
    chk("game_over_set", int'(game_over), 1);
    touch(TM, 1);
    touch(TU, 1);
    idle(20);
    chk("over_freeze", int'(freeze), 1);

    do_reset();
    for (int i = 0; i < 10; i++) touch(TU, 1);
    idle(6);
    chk("life_sat", int'(life_cnt), 9);

    touch(TM, 1);
    run_ticks(20);
    do_reset();
    idle(3);
    chk("rst_mid_grow_pw", int'(power_state), 0);

    for (int it = 0; it < 3000; it++) begin
      logic [3:0] t;
      t[0] = ($urandom_range(0, 7) == 0);
      t[1] = ($urandom_range(0, 9) == 0);
      t[2] = ($urandom_range(0, 7) == 0);
      t[3] = ($urandom_range(0, 11) == 0);
      for (int h = 0; h < $urandom_range(1, 3); h++) cycle(t);
      if ((m_over && $urandom_range(0, 9) == 0) ||
          $urandom_range(0, 499) == 0)
        do_reset();
    end

    idle(10);
    @(negedge sys_clk);
    #1;
    chk("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
